// File: rtl/cla_sub32_pipe_pkg.sv
// ----------------------------------------------------------------------------
// cla_sub32_pipe_pkg
//   Shared definitions for the pipelined 32-bit CLA subtractor: operand and
//   half widths, slice geometry, pipeline-register record types and the 4-bit
//   carry-lookahead slice function used by both adder halves.
//   No ports (package).
// ----------------------------------------------------------------------------
package cla_sub32_pipe_pkg;

   localparam int WIDTH   = 32;
   localparam int HALF    = 16;
   localparam int SLICE_W = 4;
   localparam int SLICES  = HALF / SLICE_W;

   // Stage-1 register contents: finished low half plus what the upper half
   // still needs (operands, carry into bit 16, sign bits for the overflow flag).
   typedef struct packed {
      logic [HALF-1:0] d_lo;
      logic            c16;
      logic [HALF-1:0] a_hi;
      logic [HALF-1:0] nb_hi;
      logic            a_msb;
      logic            b_msb;
   } s1_t;

   // Stage-2 (output) register contents.
   typedef struct packed {
      logic [WIDTH-1:0] d;
      logic             bo;
      logic             ov;
   } s2_t;

   // One 4-bit carry-lookahead slice. Returns {carry_out, sum[3:0]}; every
   // internal carry is a flat sum of products of g/p and ci, so nothing
   // ripples inside the slice.
   function automatic logic [SLICE_W:0] cla4(input logic [SLICE_W-1:0] x,
                                             input logic [SLICE_W-1:0] y,
                                             input logic               ci);
      logic [SLICE_W-1:0] g;
      logic [SLICE_W-1:0] p;
      logic [SLICE_W:0]   c;
      g    = x & y;
      p    = x ^ y;
      c[0] = ci;
      c[1] = g[0] | (p[0] & ci);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & ci);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);
      return {c[4], p ^ c[SLICE_W-1:0]};
   endfunction

endpackage

// File: rtl/cla_sub32_pipe_if.sv
// ----------------------------------------------------------------------------
// cla_sub32_pipe_if
//   Operand and result streams of the pipelined subtractor, each with a
//   valid/ready handshake.
//   Signals:
//     in_valid / in_ready   operand handshake
//     a, b, bi              minuend, subtrahend, borrow in
//     out_valid / out_ready result handshake
//     d, bo, ov             difference, borrow out, signed overflow
//   Modports:
//     master  producer of operands and consumer of results
//     slave   the subtractor
// ----------------------------------------------------------------------------
interface cla_sub32_pipe_if
   import cla_sub32_pipe_pkg::*;
   ;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bi;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] d;
   logic             bo;
   logic             ov;

   modport master (
      output in_valid, a, b, bi, out_ready,
      input  in_ready, out_valid, d, bo, ov
   );

   modport slave (
      input  in_valid, a, b, bi, out_ready,
      output in_ready, out_valid, d, bo, ov
   );

endinterface

// File: rtl/cla_sub32_pipe_cla16.sv
// ----------------------------------------------------------------------------
// cla_sub32_pipe_cla16
//   16-bit adder built from four 4-bit carry-lookahead slices; group carries
//   ripple from slice to slice.
//   Ports:
//     x, y  [15:0]  addends
//     ci            carry in
//     s     [15:0]  sum
//     co            carry out of bit 15
// ----------------------------------------------------------------------------
module cla_sub32_pipe_cla16
   import cla_sub32_pipe_pkg::*;
(
   input  logic [HALF-1:0] x,
   input  logic [HALF-1:0] y,
   input  logic            ci,
   output logic [HALF-1:0] s,
   output logic            co
);

   logic [SLICES:0] carry;

   assign carry[0] = ci;

   for (genvar i = 0; i < SLICES; i++) begin : g_slice
      assign {carry[i+1], s[i*SLICE_W +: SLICE_W]} =
         cla4(x[i*SLICE_W +: SLICE_W], y[i*SLICE_W +: SLICE_W], carry[i]);
   end

   assign co = carry[SLICES];

endmodule

// File: rtl/cla_sub32_pipe.sv
// ----------------------------------------------------------------------------
// cla_sub32_pipe
//   Two-stage pipelined 32-bit subtractor: d = a - b - bi, computed as
//   a + ~b + ~bi. Stage 1 adds the low halves, stage 2 (the output register)
//   adds the high halves using the registered carry into bit 16.
//   Valid/ready on both sides with full backpressure, at most two items held.
//   Ports:
//     clk      clock, rising edge
//     reset_n  synchronous active-low reset; drops everything in flight
//     bus      cla_sub32_pipe_if.slave (operand and result streams)
// ----------------------------------------------------------------------------
module cla_sub32_pipe
   import cla_sub32_pipe_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset_n,
   cla_sub32_pipe_if.slave      bus
);

   logic            s1_valid;
   logic            out_valid;
   s1_t             s1_q;
   s1_t             s1_next;
   s2_t             s2_q;
   s2_t             s2_next;

   logic            s2_ready;
   logic            in_ready;
   logic            in_fire;
   logic            s1_fire;

   logic [WIDTH-1:0] nb;
   logic [HALF-1:0]  lo_sum;
   logic             lo_co;
   logic [HALF-1:0]  hi_sum;
   logic             hi_co;

   // Subtraction as addition: invert the subtrahend, carry in = not borrow in.
   assign nb = ~bus.b;

   cla_sub32_pipe_cla16 u_lo (
      .x  (bus.a[HALF-1:0]),
      .y  (nb[HALF-1:0]),
      .ci (~bus.bi),
      .s  (lo_sum),
      .co (lo_co)
   );

   cla_sub32_pipe_cla16 u_hi (
      .x  (s1_q.a_hi),
      .y  (s1_q.nb_hi),
      .ci (s1_q.c16),
      .s  (hi_sum),
      .co (hi_co)
   );

   // Output stage frees up when empty or being consumed; stage 1 accepts when
   // empty or when it can pass its item on. The in_ready path from out_ready is
   // combinational so a full pipe resumes in the same cycle out_ready rises.
   assign s2_ready = ~out_valid | bus.out_ready;
   assign in_ready = ~s1_valid | s2_ready;
   assign in_fire  = bus.in_valid & in_ready;
   assign s1_fire  = s1_valid & s2_ready;

   always_comb begin
      // NOTE: every always_comb output gets a full default first so no path
      // leaves it unassigned and a latch is never inferred.
      s1_next       = '0;
      s1_next.d_lo  = lo_sum;
      s1_next.c16   = lo_co;
      s1_next.a_hi  = bus.a[WIDTH-1:HALF];
      s1_next.nb_hi = nb[WIDTH-1:HALF];
      s1_next.a_msb = bus.a[WIDTH-1];
      s1_next.b_msb = bus.b[WIDTH-1];

      s2_next    = '0;
      s2_next.d  = {hi_sum, s1_q.d_lo};
      // No carry out of bit 31 means the subtraction borrowed.
      s2_next.bo = ~hi_co;
      // Overflow only when operand signs differ and the result sign flips
      // away from the minuend.
      s2_next.ov = (s1_q.a_msb ^ s1_q.b_msb) & (hi_sum[HALF-1] ^ s1_q.a_msb);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1_valid  <= 1'b0;
         out_valid <= 1'b0;
         s1_q      <= '0;
         s2_q      <= '0;
      end else begin
         s1_valid  <= in_fire | (s1_valid & ~s1_fire);
         out_valid <= s1_fire | (out_valid & ~bus.out_ready);
         if (in_fire) s1_q <= s1_next;
         if (s1_fire) s2_q <= s2_next;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.d         = s2_q.d;
   assign bus.bo        = s2_q.bo;
   assign bus.ov        = s2_q.ov;

endmodule

// File: tb/tb_cla_sub32_pipe.sv
// ----------------------------------------------------------------------------
// tb_cla_sub32_pipe
//   Directed self-checking bench for cla_sub32_pipe: reset state, a table of
//   hand-computed vectors streamed back-to-back, a backpressure sequence and a
//   reset with two items in flight.
// ----------------------------------------------------------------------------
module tb_cla_sub32_pipe;

   logic clk;
   logic reset_n;

   cla_sub32_pipe_if bus ();

   cla_sub32_pipe dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        bi;
      logic [31:0] d;
      logic        bo;
      logic        ov;
   } vec_t;

   localparam int NVEC = 13;
   vec_t vecs [NVEC];

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic bi);
      bus.in_valid = v;
      bus.a        = a;
      bus.b        = b;
      bus.bi       = bi;
   endtask

   initial begin
      vecs[0]  = '{32'd5,         32'd3,         1'b0, 32'd2,         1'b0, 1'b0};
      vecs[1]  = '{32'd0,         32'd1,         1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
      vecs[2]  = '{32'h8000_0000, 32'd1,         1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};
      vecs[3]  = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1};
      vecs[4]  = '{32'h0001_0000, 32'd1,         1'b1, 32'h0000_FFFE, 1'b0, 1'b0};
      vecs[5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
      vecs[6]  = '{32'd0,         32'd0,         1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
      vecs[7]  = '{32'h1234_5678, 32'd1,         1'b0, 32'h1234_5677, 1'b0, 1'b0};
      vecs[8]  = '{32'd0,         32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1, 1'b1};
      vecs[9]  = '{32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 32'hFFFE_0001, 1'b0, 1'b0};
      vecs[10] = '{32'd0,         32'd0,         1'b0, 32'h0000_0000, 1'b0, 1'b0};
      vecs[11] = '{32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 32'hCC79_6876, 1'b0, 1'b0};
      vecs[12] = '{32'h0001_0000, 32'd0,         1'b1, 32'h0000_FFFF, 1'b0, 1'b0};

      // Reset
      reset_n       = 1'b0;
      bus.out_ready = 1'b1;
      drive(1'b0, 32'd0, 32'd0, 1'b0);
      tick();
      tick();
      reset_n = 1'b1;
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
      check("rst_d",         bus.d,                  32'd0);
      check("rst_bo",        {31'd0, bus.bo},        32'd0);
      check("rst_ov",        {31'd0, bus.ov},        32'd0);

      // Table: one vector per cycle, result expected one cycle after accept.
      for (int i = 0; i <= NVEC; i++) begin
         if (i < NVEC) begin
            drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].bi);
            check($sformatf("vec%0d_in_ready", i), {31'd0, bus.in_ready}, 32'd1);
         end else begin
            drive(1'b0, 32'd0, 32'd0, 1'b0);
         end
         tick();
         if (i == 0) begin
            check("latency_no_early_valid", {31'd0, bus.out_valid}, 32'd0);
         end else begin
            check($sformatf("vec%0d_valid", i-1), {31'd0, bus.out_valid}, 32'd1);
            check($sformatf("vec%0d_d",     i-1), bus.d,                  vecs[i-1].d);
            check($sformatf("vec%0d_bo",    i-1), {31'd0, bus.bo},        {31'd0, vecs[i-1].bo});
            check($sformatf("vec%0d_ov",    i-1), {31'd0, bus.ov},        {31'd0, vecs[i-1].ov});
         end
      end
      tick();
      check("drain_valid", {31'd0, bus.out_valid}, 32'd0);

      // Backpressure: 10-1, 20-2, 30-3 with out_ready low.
      bus.out_ready = 1'b0;
      drive(1'b1, 32'd10, 32'd1, 1'b0);
      check("bp_accept1_ready", {31'd0, bus.in_ready}, 32'd1);
      tick();
      drive(1'b1, 32'd20, 32'd2, 1'b0);
      check("bp_accept2_ready", {31'd0, bus.in_ready}, 32'd1);
      tick();
      check("bp_first_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_first_d",     bus.d,                  32'd9);
      drive(1'b1, 32'd30, 32'd3, 1'b0);
      check("bp_full_ready", {31'd0, bus.in_ready}, 32'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         check($sformatf("bp_stall%0d_ready", c), {31'd0, bus.in_ready},  32'd0);
         check($sformatf("bp_stall%0d_valid", c), {31'd0, bus.out_valid}, 32'd1);
         check($sformatf("bp_stall%0d_d",     c), bus.d,                  32'd9);
      end
      bus.out_ready = 1'b1;
      #1;
      check("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
      check("bp_release_d",     bus.d,                 32'd9);
      tick();
      drive(1'b0, 32'd0, 32'd0, 1'b0);
      check("bp_second_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_second_d",     bus.d,                  32'd18);
      tick();
      check("bp_third_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_third_d",     bus.d,                  32'd27);
      tick();
      check("bp_empty_valid", {31'd0, bus.out_valid}, 32'd0);

      // Reset with two items in flight.
      bus.out_ready = 1'b0;
      drive(1'b1, 32'd100, 32'd1, 1'b0);
      tick();
      drive(1'b1, 32'd200, 32'd2, 1'b0);
      tick();
      drive(1'b0, 32'd0, 32'd0, 1'b0);
      check("mr_full_ready", {31'd0, bus.in_ready}, 32'd0);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check("mr_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("mr_in_ready",  {31'd0, bus.in_ready},  32'd1);
      check("mr_d",         bus.d,                  32'd0);
      bus.out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         check($sformatf("mr_no_ghost%0d", c), {31'd0, bus.out_valid}, 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
